nabp_filtered_line_sink: RTL

//  Far end of the projection filter. Drives the filter's enable/clear for one projection line,

---
 rtl/nabp_filtered_line_sink_pkg.sv | 20 ++
 rtl/nabp_filtered_line_sink_line_ram.sv | 37 +++
 rtl/nabp_filtered_line_sink.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/nabp_filtered_line_sink_pkg.sv
// Shared parameters and fill-state encodings for the NABP filtered line sink.
// Optional ping-pong buffering is selected in the top module with NABP_SINK_PINGPONG_EN.
package nabp_filtered_line_sink_pkg;

   // DATA_W default stands in for the filter's filtered-data width.
   localparam int NABP_DATA_W       = 16;
   localparam int NABP_LINE_LEN     = 256;
   localparam int NABP_FILTER_DELAY = 8;
   localparam int NABP_ADDR_W       = 8;

   localparam logic [1:0] FILL_IDLE  = 2'd0;
   localparam logic [1:0] FILL_CLR   = 2'd1;
   localparam logic [1:0] FILL_RUN   = 2'd2;
   localparam logic [1:0] FILL_FLUSH = 2'd3;

   function automatic logic next_buf(input logic sel, input int nbuf);
      return (nbuf > 1) ? ~sel : 1'b0;
   endfunction

endpackage

// File: rtl/nabp_filtered_line_sink_line_ram.sv
// One line buffer: 1W/1R synchronous RAM with a registered, enable-held read port.
module nabp_line_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              clear_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read data only moves on rd_en so a stalled consumer sees a stable word.
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nabp_filtered_line_sink.sv
// Filter far end: drives NABPFilter enable/clear, captures delay-aligned samples, drains lines.
// Define NABP_SINK_PINGPONG_EN for two line buffers (fill overlaps drain); default is one buffer.
module nabp_filtered_line_sink
   import nabp_filtered_line_sink_pkg::*;
#(
   parameter int DATA_W       = NABP_DATA_W,
   parameter int LINE_LEN     = NABP_LINE_LEN,
   parameter int FILTER_DELAY = NABP_FILTER_DELAY,
   parameter int ADDR_W       = NABP_ADDR_W
) (
   input  logic              clk_i,
   input  logic              clear_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              filter_enable_o,
   output logic              filter_clear_o,
   output logic              filter_flush_o,
   input  logic [DATA_W-1:0] filter_val_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [ADDR_W-1:0] out_index_o,
   output logic              out_last_o
);

`ifdef NABP_SINK_PINGPONG_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif
   localparam int ECW = $clog2(LINE_LEN + FILTER_DELAY + 1);
   localparam int FCW = $clog2(FILTER_DELAY + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

   logic [1:0]        fill_q, fill_d;
   logic [ADDR_W-1:0] acc_q, acc_d;
   logic [FCW-1:0]    flush_q, flush_d;
   logic [ECW-1:0]    ecnt_q, ecnt_d;
   logic              wr_sel_q, wr_sel_d;
   logic              rst_tail_q;
   logic              claim_s;
   logic              filter_en_s;
   logic              cap_v_q, cap_v_d;
   logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic              cap_buf_q, cap_buf_d;
   logic [1:0]        busy_q, busy_d, full_q, full_d, free_s;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              rd_sel_q, rd_sel_d;
   logic              rd_en_s, rd_buf_s, nxt_s, hs_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [DATA_W-1:0] rd_data_s [2];

   assign filter_en_s = (fill_q == FILL_RUN) ? in_valid_i : (fill_q == FILL_FLUSH);

   // Fill FSM plus enable counter; capture trails each enable by one cycle.
   always_comb begin
      fill_d   = fill_q;
      acc_d    = acc_q;
      flush_d  = flush_q;
      ecnt_d   = ecnt_q;
      wr_sel_d = wr_sel_q;
      claim_s  = 1'b0;
      case (fill_q)
         FILL_IDLE: begin
            if (in_valid_i && !busy_q[wr_sel_q]) begin
               fill_d  = FILL_CLR;
               claim_s = 1'b1;
            end else begin
               fill_d = FILL_IDLE;
            end
         end
         FILL_CLR: begin
            fill_d  = FILL_RUN;
            acc_d   = '0;
            flush_d = '0;
            ecnt_d  = '0;
         end
         FILL_RUN: begin
            if (in_valid_i) begin
               acc_d  = acc_q + 1'b1;
               fill_d = (acc_q == LAST_ADDR) ? FILL_FLUSH : FILL_RUN;
            end else begin
               fill_d = FILL_RUN;
            end
         end
         FILL_FLUSH: begin
            flush_d = flush_q + 1'b1;
            if (flush_q == FCW'(FILTER_DELAY - 1)) begin
               fill_d   = FILL_IDLE;
               wr_sel_d = next_buf(wr_sel_q, NBUF);
            end else begin
               fill_d = FILL_FLUSH;
            end
         end
         default: fill_d = FILL_IDLE;
      endcase
      if (filter_en_s) begin
         ecnt_d = ecnt_q + 1'b1;
      end else begin
         ecnt_d = ecnt_d;
      end
      // The e-th enable (e = ecnt_q+1) lands at address e-FILTER_DELAY-1 once the pipe is primed.
      cap_v_d    = filter_en_s && (ecnt_q >= ECW'(FILTER_DELAY));
      cap_addr_d = ADDR_W'(ecnt_q - ECW'(FILTER_DELAY));
      cap_buf_d  = wr_sel_q;
   end

   // Drain FSM: advance on handshake, hop straight to the other full buffer after the last word.
   always_comb begin
      out_valid_d = out_valid_q;
      idx_d       = idx_q;
      rd_sel_d    = rd_sel_q;
      rd_en_s     = 1'b0;
      rd_buf_s    = rd_sel_q;
      rd_addr_s   = '0;
      free_s      = 2'b00;
      hs_s        = out_valid_q && out_ready_i;
      nxt_s       = next_buf(rd_sel_q, NBUF);
      if (hs_s && (idx_q != LAST_ADDR)) begin
         rd_en_s   = 1'b1;
         rd_addr_s = idx_q + 1'b1;
         idx_d     = idx_q + 1'b1;
      end else if (hs_s) begin
         free_s[rd_sel_q] = 1'b1;
         rd_sel_d         = nxt_s;
         idx_d            = '0;
         if (full_q[nxt_s] && (nxt_s != rd_sel_q)) begin
            rd_en_s  = 1'b1;
            rd_buf_s = nxt_s;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (!out_valid_q && full_q[rd_sel_q]) begin
         rd_en_s     = 1'b1;
         idx_d       = '0;
         out_valid_d = 1'b1;
      end else begin
         out_valid_d = out_valid_q;
      end
      busy_d = busy_q & ~free_s;
      full_d = full_q & ~free_s;
      if (claim_s) begin
         busy_d[wr_sel_q] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      if (cap_v_q && (cap_addr_q == LAST_ADDR)) begin
         full_d[cap_buf_q] = 1'b1;
      end else begin
         full_d = full_d;
      end
   end

   // State registers; clear aborts both FSMs and drops every buffered line.
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         fill_q      <= FILL_IDLE;
         acc_q       <= '0;
         flush_q     <= '0;
         ecnt_q      <= '0;
         wr_sel_q    <= 1'b0;
         rst_tail_q  <= 1'b1;
         cap_v_q     <= 1'b0;
         cap_addr_q  <= '0;
         cap_buf_q   <= 1'b0;
         busy_q      <= 2'b00;
         full_q      <= 2'b00;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
         rd_sel_q    <= 1'b0;
      end else begin
         fill_q      <= fill_d;
         acc_q       <= acc_d;
         flush_q     <= flush_d;
         ecnt_q      <= ecnt_d;
         wr_sel_q    <= wr_sel_d;
         rst_tail_q  <= 1'b0;
         cap_v_q     <= cap_v_d;
         cap_addr_q  <= cap_addr_d;
         cap_buf_q   <= cap_buf_d;
         busy_q      <= busy_d;
         full_q      <= full_d;
         out_valid_q <= out_valid_d;
         idx_q       <= idx_d;
         rd_sel_q    <= rd_sel_d;
      end
   end

   for (genvar b = 0; b < NBUF; b++) begin : g_buf
      nabp_line_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (LINE_LEN),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clk_i     (clk_i),
         .clear_i   (clear_i),
         .wr_en_i   (cap_v_q && (cap_buf_q == 1'(b))),
         .wr_addr_i (cap_addr_q),
         .wr_data_i (filter_val_i),
         .rd_en_i   (rd_en_s && (rd_buf_s == 1'(b))),
         .rd_addr_i (rd_addr_s),
         .rd_data_o (rd_data_s[b])
      );
   end
   if (NBUF == 1) begin : g_no_pp
      assign rd_data_s[1] = '0;
   end

   assign in_ready_o      = (fill_q == FILL_RUN);
   assign filter_enable_o = filter_en_s;
   assign filter_clear_o  = rst_tail_q || (fill_q == FILL_CLR);
   assign filter_flush_o  = (fill_q == FILL_FLUSH);
   assign out_valid_o     = out_valid_q;
   assign out_data_o      = rd_data_s[rd_sel_q];
   assign out_index_o     = idx_q;
   assign out_last_o      = out_valid_q && (idx_q == LAST_ADDR);

endmodule
